// File: rtl/tdpram.sv
// True dual-port RAM with byte enables and 1-cycle registered reads on both ports.
// Define DPRAM_CLEAR_EN to add a post-reset sweep that zeroes every word while busy is high.
module tdpram #(
    parameter int    DATA_W        = 8,
    parameter int    ADDR_W        = 16,
    parameter int    RDW_MODE      = 0,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we_a,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W-1:0]   din_a,
    output logic [DATA_W-1:0]   dout_a,
    input  logic                we_b,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W-1:0]   din_b,
    output logic [DATA_W-1:0]   dout_b,
    output logic                busy,
    output logic                collision
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              active;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

`ifdef DPRAM_CLEAR_EN
    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_q;
    state_t            state_d;
    // One extra bit so the count reaching DEPTH-1 never aliases back to 0.
    logic [ADDR_W:0]   clr_cnt;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) clr_cnt <= clr_cnt + {{ADDR_W{1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && clr_cnt == LAST) state_d = READY;
    end

    always_comb begin
        busy     = (state_q == CLEAR);
        clr_we   = busy && !reset;
        active   = !busy && !reset;
        clr_addr = clr_cnt[ADDR_W-1:0];
    end
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign active   = !reset;
    assign clr_addr = '0;
`endif

    logic                same_addr;
    logic [DATA_W-1:0]   old_a;
    logic [DATA_W-1:0]   old_b;
    logic [DATA_W-1:0]   merged_a;
    logic [DATA_W-1:0]   merged_b;

    assign same_addr = (addr_a == addr_b);

    always_comb begin
        old_a    = mem[addr_a];
        old_b    = mem[addr_b];
        merged_a = old_a;
        merged_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (be_a[i]) merged_a[i*8 +: 8] = din_a[i*8 +: 8];
            if (be_b[i]) merged_b[i*8 +: 8] = din_b[i*8 +: 8];
        end
    end

    // Port A owns any byte both ports enable on a shared address.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (active) begin
            for (int i = 0; i < NB; i++) begin
                if (we_b && be_b[i] && !(same_addr && we_a && be_a[i]))
                    mem[addr_b][i*8 +: 8] <= din_b[i*8 +: 8];
                if (we_a && be_a[i])
                    mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
            end
        end
    end

    // Cross-port reads always see the pre-write word; only the own-port path may bypass.
    always_ff @(posedge clk) begin
        if (!active) begin
            dout_a    <= '0;
            dout_b    <= '0;
            collision <= 1'b0;
        end else begin
            dout_a    <= (RDW_MODE == 1 && we_a) ? merged_a : old_a;
            dout_b    <= (RDW_MODE == 1 && we_b) ? merged_b : old_b;
            collision <= we_a && we_b && same_addr && ((be_a & be_b) != '0);
        end
    end

endmodule

// File: tb/tb_tdpram.sv
// Scoreboard bench for tdpram: read-first and write-first instances share one stimulus stream.
module tb_tdpram;

    logic        clk = 1'b0;
    logic        reset;
    logic        we_a, we_b;
    logic [1:0]  be_a, be_b;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] din_a, din_b;
    logic [15:0] rf_dout_a, rf_dout_b, wf_dout_a, wf_dout_b;
    logic        rf_busy, wf_busy, rf_coll, wf_coll;

    always #5 clk = ~clk;

    tdpram #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0)) u_rf (
        .clk(clk), .reset(reset),
        .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a), .dout_a(rf_dout_a),
        .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b), .dout_b(rf_dout_b),
        .busy(rf_busy), .collision(rf_coll)
    );

    tdpram #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1)) u_wf (
        .clk(clk), .reset(reset),
        .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a), .dout_a(wf_dout_a),
        .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b), .dout_b(wf_dout_b),
        .busy(wf_busy), .collision(wf_coll)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mdl [16];
    bit          known [16];
    bit          mclr = 1'b0;
    int          mcnt = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    string       names [8] = '{"rf_a", "rf_b", "wf_a", "wf_b", "rf_coll", "wf_coll", "rf_busy", "wf_busy"};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = din[7:0];
        if (be[1]) r[15:8] = din[15:8];
        return r;
    endfunction

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            0: return rf_dout_a;
            1: return rf_dout_b;
            2: return wf_dout_a;
            3: return wf_dout_b;
            4: return {15'b0, rf_coll};
            5: return {15'b0, wf_coll};
            6: return {15'b0, rf_busy};
            default: return {15'b0, wf_busy};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [15:0] exp);
        exp_t e;
        e.tag = {tag, "/", names[sel]};
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic set_a(input logic we, input logic [1:0] be, input logic [3:0] addr, input logic [15:0] din);
        we_a = we; be_a = be; addr_a = addr; din_a = din;
    endtask

    task automatic set_b(input logic we, input logic [1:0] be, input logic [3:0] addr, input logic [15:0] din);
        we_b = we; be_b = be; addr_b = addr; din_b = din;
    endtask

    task automatic idle();
        set_a(1'b0, 2'b00, 4'd0, 16'h0);
        set_b(1'b0, 2'b00, 4'd0, 16'h0);
    endtask

    // Predict the outputs for the coming edge, advance the model, then compare after the edge.
    task automatic step(input string tag);
        exp_t        e;
        logic [15:0] old_a, old_b;
        logic        coll;
        if (reset || mclr) begin
            for (int s = 0; s < 6; s++) push(tag, s, 16'h0);
            if (reset) begin
`ifdef DPRAM_CLEAR_EN
                mclr = 1'b1;
                mcnt = 0;
`endif
            end else begin
                mdl[mcnt]   = 16'h0;
                known[mcnt] = 1'b1;
                mcnt++;
                if (mcnt == 16) mclr = 1'b0;
            end
        end else begin
            old_a = mdl[addr_a];
            old_b = mdl[addr_b];
            if (known[addr_a]) push(tag, 0, old_a);
            if (known[addr_b]) push(tag, 1, old_b);
            if (known[addr_a] || (we_a && be_a == 2'b11)) push(tag, 2, we_a ? merge(old_a, din_a, be_a) : old_a);
            if (known[addr_b] || (we_b && be_b == 2'b11)) push(tag, 3, we_b ? merge(old_b, din_b, be_b) : old_b);
            coll = we_a && we_b && (addr_a == addr_b) && ((be_a & be_b) != 2'b00);
            push(tag, 4, {15'b0, coll});
            push(tag, 5, {15'b0, coll});
            if (we_b) mdl[addr_b] = merge(mdl[addr_b], din_b, be_b);
            if (we_a) mdl[addr_a] = merge(mdl[addr_a], din_a, be_a);
            if (we_b && be_b == 2'b11) known[addr_b] = 1'b1;
            if (we_a && be_a == 2'b11) known[addr_a] = 1'b1;
        end
        push(tag, 6, {15'b0, mclr});
        push(tag, 7, {15'b0, mclr});
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic finish_clear();
        int guard;
        guard = 0;
        while (mclr && guard < 40) begin
            idle();
            step("sweep");
            guard++;
        end
        check("sweep_bound", {15'b0, mclr}, 16'h0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        step("rst");
        step("rst");
        reset = 1'b0;

`ifdef DPRAM_CLEAR_EN
        for (int i = 0; i < 9; i++) begin
            if (i == 3) begin
                set_a(1'b1, 2'b11, 4'd2, 16'hFFFF);
                set_b(1'b1, 2'b11, 4'd2, 16'hEEEE);
            end else idle();
            step("clr1");
        end
        idle();
        reset = 1'b1;
        step("clr_rst");
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) set_a(1'b1, 2'b11, 4'd2, 16'hFFFF);
            else idle();
            step("clr2");
        end
        check("clr_done_busy", {15'b0, rf_busy}, 16'h0);
        for (int i = 0; i < 16; i++) begin
            set_a(1'b0, 2'b00, 4'(i), 16'h0);
            set_b(1'b0, 2'b00, 4'(15 - i), 16'h0);
            step("clr_rd");
        end
`endif

        for (int i = 0; i < 8; i++) begin
            set_a(1'b1, 2'b11, 4'(2 * i), 16'($urandom));
            set_b(1'b1, 2'b11, 4'(2 * i + 1), 16'($urandom));
            step("init");
        end

        idle();
        set_a(1'b1, 2'b11, 4'd3, 16'hABCD); step("bm1");
        set_a(1'b1, 2'b01, 4'd3, 16'h1234); step("bm2");
        set_a(1'b0, 2'b00, 4'd3, 16'h0);    step("bm_rd");
        check("bm_val", rf_dout_a, 16'hAB34);

        set_a(1'b1, 2'b11, 4'd5, 16'h1111); step("rdw0");
        set_a(1'b1, 2'b11, 4'd5, 16'h2222);
        set_b(1'b0, 2'b00, 4'd5, 16'h0);    step("rdw_a");
        check("rdw_rf_a", rf_dout_a, 16'h1111);
        check("rdw_wf_a", wf_dout_a, 16'h2222);
        check("rdw_rf_b", rf_dout_b, 16'h1111);
        check("rdw_wf_b", wf_dout_b, 16'h1111);
        set_b(1'b1, 2'b11, 4'd5, 16'h3333);
        set_a(1'b0, 2'b00, 4'd5, 16'h0);    step("rdw_b");
        check("rdw_wf_b2", wf_dout_b, 16'h3333);
        check("rdw_wf_a2", wf_dout_a, 16'h2222);

        idle();
        set_a(1'b1, 2'b10, 4'd7, 16'hAAAA);
        set_b(1'b1, 2'b11, 4'd7, 16'hBBBB); step("col1");
        check("col1_pulse", {15'b0, rf_coll}, 16'h1);
        idle();
        set_a(1'b0, 2'b00, 4'd7, 16'h0);    step("col1_rd");
        check("col1_val", rf_dout_a, 16'hAABB);
        check("col1_drop", {15'b0, wf_coll}, 16'h0);
        set_a(1'b1, 2'b11, 4'd7, 16'h0000); step("col2_clr");
        set_a(1'b1, 2'b10, 4'd7, 16'hAAAA);
        set_b(1'b1, 2'b01, 4'd7, 16'hBBBB); step("col2");
        check("col2_none", {15'b0, rf_coll}, 16'h0);
        idle();
        set_b(1'b0, 2'b00, 4'd7, 16'h0);    step("col2_rd");
        check("col2_val", rf_dout_b, 16'hAABB);

        set_a(1'b1, 2'b11, 4'd8, 16'h1357);
        set_b(1'b1, 2'b11, 4'd9, 16'h2468); step("diff");
        set_a(1'b1, 2'b00, 4'd8, 16'hFFFF);
        set_b(1'b0, 2'b00, 4'd9, 16'h0);    step("be0");
        set_a(1'b0, 2'b00, 4'd8, 16'h0);    step("be0_rd");
        check("be0_val", rf_dout_a, 16'h1357);
        check("diff_b", rf_dout_b, 16'h2468);

        set_a(1'b1, 2'b11, 4'd0, 16'h5A5A); step("pre_rst");
        idle();
        reset = 1'b1;
        step("mid_rst");
        reset = 1'b0;
        finish_clear();
        set_a(1'b0, 2'b00, 4'd0, 16'h0);    step("post_rst_rd");
`ifdef DPRAM_CLEAR_EN
        check("post_rst_val", rf_dout_a, 16'h0000);
`else
        check("post_rst_val", rf_dout_a, 16'h5A5A);
`endif

        for (int i = 0; i < 60; i++) begin
            set_a(1'($urandom), 2'($urandom), 4'($urandom_range(0, 3)), 16'($urandom));
            set_b(1'($urandom), 2'($urandom), 4'($urandom_range(0, 3)), 16'($urandom));
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
